// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^m) widths, constants and operand reduction for m = 2..4.
package gf_pkg;
    localparam int ELEM_W  = 4;
    localparam int POLY_W  = 5;
    localparam int MAX_DEG = 4;
    localparam logic [POLY_W-1:0] POLY_X2X1 = 5'b00111;

    function automatic logic [ELEM_W-1:0] gf_reduce(
        input logic [ELEM_W-1:0] value,
        input logic [POLY_W-1:0] poly,
        input logic [2:0]        m
    );
        logic [7:0] v;
        v = {4'b0, value};
        for (int p = ELEM_W - 1; p >= 2; p--)
            if (p >= int'(m) && v[p]) v = v ^ ({3'b0, poly} << (p - int'(m)));
        return v[ELEM_W-1:0];
    endfunction
endpackage

// File: rtl/gf_poly_check.sv
// gf_poly_check: combinational validity check of a degree-m field polynomial.
module gf_poly_check
    import gf_pkg::*;
(
    input  logic [2:0]        m,
    input  logic [POLY_W-1:0] prim_poly,
    output logic              poly_ok
);
    logic [POLY_W-1:0] rem;
    logic              deg_ok;

    always_comb begin
        rem = prim_poly;
        // remainder modulo x^2+x+1 catches the only reducible root-free quartic
        for (int p = POLY_W - 1; p >= 2; p--)
            if (rem[p]) rem = rem ^ (POLY_X2X1 << (p - 2));
        deg_ok  = (m >= 3'd2) && (m <= 3'(MAX_DEG)) && ((prim_poly >> m) == 5'd1);
        poly_ok = deg_ok && prim_poly[0] && (^prim_poly) && (m != 3'(MAX_DEG) || rem != '0);
    end
endmodule

// File: rtl/gf_adder4.sv
// gf_adder4: registered GF(2^m) adder; reduces both operands into the field and XORs them.
module gf_adder4
    import gf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [2:0]        m,
    input  logic [POLY_W-1:0] prim_poly,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ELEM_W-1:0] opelement,
    output logic              out_valid,
    output logic              poly_err
);
    logic              poly_ok;
    logic [ELEM_W-1:0] red_a, red_b, mask, sum;
    logic [ELEM_W-1:0] opelement_d, opelement_q;
    logic              out_valid_d, out_valid_q;
    logic              poly_err_d, poly_err_q;

    gf_poly_check u_check (
        .m         (m),
        .prim_poly (prim_poly),
        .poly_ok   (poly_ok)
    );

    always_comb begin
        red_a       = gf_reduce(a, prim_poly, m);
        red_b       = gf_reduce(b, prim_poly, m);
        mask        = ~(4'hF << m);
        sum         = (red_a ^ red_b) & mask;
        out_valid_d = in_valid;
        opelement_d = in_valid ? (poly_ok ? sum : '0) : opelement_q;
        poly_err_d  = in_valid ? !poly_ok : poly_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opelement_q <= '0;
            out_valid_q <= 1'b0;
            poly_err_q  <= 1'b0;
        end else begin
            opelement_q <= opelement_d;
            out_valid_q <= out_valid_d;
            poly_err_q  <= poly_err_d;
        end
    end

    assign opelement = opelement_q;
    assign out_valid = out_valid_q;
    assign poly_err  = poly_err_q;
endmodule

// File: tb/tb_gf_adder4.sv
// tb_gf_adder4: scoreboard bench; polynomial-remainder reference model, directed plus random ops.
module tb_gf_adder4;
    logic       clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0;
    logic [2:0] m = '0;
    logic [4:0] prim_poly = '0;
    logic [3:0] a = '0, b = '0;
    logic [3:0] opelement;
    logic       out_valid, poly_err;

    typedef struct {
        logic [3:0] elem;
        logic       err;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, errors = 0;
    logic [3:0] last_elem = '0;
    logic       last_err  = 1'b0;

    gf_adder4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .m         (m),
        .prim_poly (prim_poly),
        .a         (a),
        .b         (b),
        .opelement (opelement),
        .out_valid (out_valid),
        .poly_err  (poly_err)
    );

    always #5 clk = ~clk;

    function automatic int deg(logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    // polynomial remainder by repeated long-division steps
    function automatic logic [7:0] clmod(logic [7:0] v, logic [7:0] p);
        if (p == 0) return v;
        while (v != 0 && deg(v) >= deg(p)) v = v ^ (p << (deg(v) - deg(p)));
        return v;
    endfunction

    function automatic bit cfg_ok(int md, logic [4:0] p);
        if (md < 2 || md > 4) return 0;
        if (deg({3'b0, p}) != md || !p[0] || ($countones(p) % 2) == 0) return 0;
        if (md == 4 && clmod({3'b0, p}, 8'd7) == 0) return 0;
        return 1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(string tag, int md, logic [4:0] p, logic [3:0] aa, logic [3:0] bb);
        exp_t e;
        @(negedge clk);
        m = md[2:0]; prim_poly = p; a = aa; b = bb; in_valid = 1'b1;
        e.tag  = tag;
        e.err  = !cfg_ok(md, p);
        e.elem = e.err ? 4'd0 : 4'(clmod({4'b0, aa}, {3'b0, p}) ^ clmod({4'b0, bb}, {3'b0, p}));
        sb.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = 4'($urandom); b = 4'($urandom);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk({e.tag, "_elem"}, opelement, e.elem);
                    chk({e.tag, "_err"}, poly_err, e.err);
                    last_elem = e.elem;
                    last_err  = e.err;
                end
            end else begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({e.tag, "_missing_out_valid"}, 0, 1);
                end
                chk("hold_elem", opelement, last_elem);
                chk("hold_err", poly_err, last_err);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_elem", opelement, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_err", poly_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue("inv_m2_p10000", 2, 5'b10000, 4'd0, 4'd0);
        issue("inv_m3_p10000", 3, 5'b10000, 4'd5, 4'd3);
        issue("inv_m4_p10101", 4, 5'b10101, 4'd9, 4'd6);
        issue("inv_m5", 5, 5'b10011, 4'd3, 4'd5);

        issue("m3a_1_2", 3, 5'b01011, 4'b0001, 4'b0010);
        issue("m3a_7_4", 3, 5'b01011, 4'b0111, 4'b0100);
        issue("m3a_3_2", 3, 5'b01011, 4'b0011, 4'b0010);
        issue("m3a_1_5", 3, 5'b01011, 4'b0001, 4'b0101);
        issue("m3a_0_0", 3, 5'b01011, 4'b0000, 4'b0000);

        issue("m3b_4_2", 3, 5'b01101, 4'b0100, 4'b0010);
        issue("m3b_6_1", 3, 5'b01101, 4'b0110, 4'b0001);
        issue("m3b_7_2", 3, 5'b01101, 4'b0111, 4'b0010);
        issue("m3b_2_4", 3, 5'b01101, 4'b0010, 4'b0100);

        issue("m4_a_6", 4, 5'b10011, 4'b1010, 4'b0110);
        issue("m3_after_m4", 3, 5'b01101, 4'b0000, 4'b0000);

        issue("red_8_0", 3, 5'b01011, 4'b1000, 4'b0000);
        issue("red_8_3", 3, 5'b01011, 4'b1000, 4'b0011);

        issue("pre_idle", 4, 5'b11001, 4'b1101, 4'b0110);
        idle(2);

        issue("pre_rst", 3, 5'b01011, 4'b0001, 4'b0010);
        issue("lost", 3, 5'b01011, 4'b0101, 4'b0010);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        chk("midrst_elem", opelement, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_err", poly_err, 0);
        last_elem = '0;
        last_err  = 1'b0;
        #1 rst_n = 1'b1;
        idle(2);
        issue("post_rst", 2, 5'b00111, 4'b1111, 4'b0001);

        for (int i = 0; i < 400; i++) begin
            int md;
            logic [4:0] p;
            if ($urandom_range(0, 3) == 0) idle(1);
            else begin
                if ($urandom_range(0, 4) == 0) begin
                    md = int'($urandom_range(0, 7));
                    p  = 5'($urandom);
                end else begin
                    md = int'($urandom_range(2, 4));
                    p  = 5'((1 << md) | ($urandom & ((1 << md) - 1)) | 1);
                end
                issue("rand", md, p, 4'($urandom), 4'($urandom));
            end
        end
        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
